// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master fixed-tenure bus arbiter with alternating priority.
// Grants are registered, one-cycle latency, and each tenure is bounded by TIMEOUT cycles.
module bus_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd15
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_0,
    input  logic       req_1,
    input  logic       done_0,
    input  logic       done_1,
    output logic       grant_0,
    output logic       grant_1,
    output logic [1:0] sel,
    output logic       bus_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [7:0] cnt;
    logic       last_owner;
    logic       tmo;

    // Tenure expires on the edge closing the TIMEOUT-th granted cycle.
    assign tmo = (cnt == TIMEOUT - 8'd1);

    // Next-state: alternate on contention, hand over directly when the other side waits.
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE: begin
                if (req_0 && req_1) nxt = last_owner ? GNT0 : GNT1;
                else if (req_0)     nxt = GNT0;
                else if (req_1)     nxt = GNT1;
                else                nxt = IDLE;
            end
            GNT0: begin
                if (done_0 || !req_0 || tmo) nxt = req_1 ? GNT1 : IDLE;
                else                         nxt = GNT0;
            end
            GNT1: begin
                if (done_1 || !req_1 || tmo) nxt = req_0 ? GNT0 : IDLE;
                else                         nxt = GNT1;
            end
            default: nxt = IDLE;  // unused encoding falls back to IDLE
        endcase
    end

    // State, registered outputs, tenure counter and last-owner tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            grant_0    <= 1'b0;
            grant_1    <= 1'b0;
            sel        <= 2'b00;
            cnt        <= 8'd0;
            last_owner <= 1'b1;
        end else begin
            state   <= nxt;
            grant_0 <= (nxt == GNT0);
            grant_1 <= (nxt == GNT1);
            sel     <= {nxt == GNT1, nxt == GNT0};
            if (nxt != state)
                cnt <= 8'd0;
            else if (nxt != IDLE && cnt != 8'hFF)
                cnt <= cnt + 8'd1;
            if (nxt == GNT0 && state != GNT0)
                last_owner <= 1'b0;
            else if (nxt == GNT1 && state != GNT1)
                last_owner <= 1'b1;
        end
    end

    // Bus is busy whenever either registered grant is up.
    assign bus_busy = grant_0 | grant_1;

endmodule
